wb_stage: RTL and testbench

Writeback stage of the RV32I core, directly upstream of the register file's write port. It accepts retiring instructions from the memory stage, waits for data-memory read data on loads, aligns and sign/zero-extends it, and drives a registered one-cycle write (`reg_wr`, `reg_write_addr`, `reg_din`). It also keeps a 64-bit retired-instruction counter.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/load_align.sv | 39 +++
 rtl/wb_stage.sv | 132 +++++++++++++
 tb/tb_wb_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, load funct3 codes and the
// writeback-stage FSM state type.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: picks the byte/halfword addressed by
// addr_lo out of a word-aligned read and sign- or zero-extends it.
module load_align
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase

        // Halfword loads use only addr_lo[1]; a misaligned low bit is ignored.
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        data = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = mem_rdata;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registered single-cycle register-file write,
// load alignment and a retired-instruction counter. Optional WB_FWD_EN
// exposes the in-flight write as forwarding ports for decode.
//
// state       | meaning
// WB_IDLE     | ready; non-loads write next cycle, loads latch and wait
// WB_WAIT_MEM | load outstanding; upstream stalled until mem_rvalid
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             reg_wr,
    output logic [4:0]       reg_write_addr,
    output logic [XLEN-1:0]  reg_din,
    output logic [CNT_W-1:0] retire_count
`ifdef WB_FWD_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data
`endif
);

    wb_state_e        state_q, state_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_lo_q, ld_lo_d;
    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       addr_q, addr_d;
    logic [XLEN-1:0]  din_q, din_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             load_done;
    logic             retire;
    logic [4:0]       wr_rd;
    logic [XLEN-1:0]  wr_data;
    logic [XLEN-1:0]  aligned;

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (ld_f3_q),
        .addr_lo   (ld_lo_q),
        .data      (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:     if (in_valid && in_is_load) state_d = WB_WAIT_MEM;
            WB_WAIT_MEM: if (mem_rvalid)             state_d = WB_IDLE;
            default:     state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == WB_IDLE);
        accept    = in_ready && in_valid;
        load_done = (state_q == WB_WAIT_MEM) && mem_rvalid;
    end

    always_comb begin
        ld_rd_d = ld_rd_q;
        ld_f3_d = ld_f3_q;
        ld_lo_d = ld_lo_q;
        if (accept && in_is_load) begin
            ld_rd_d = in_rd;
            ld_f3_d = in_funct3;
            ld_lo_d = in_addr_lo;
        end

        retire  = (accept && !in_is_load) || load_done;
        wr_rd   = load_done ? ld_rd_q : in_rd;
        wr_data = load_done ? aligned : in_result;

        // x0 writes retire and count, but never reach the register file.
        reg_wr_d = retire && (wr_rd != 5'd0);
        addr_d   = reg_wr_d ? wr_rd   : addr_q;
        din_d    = reg_wr_d ? wr_data : din_q;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_lo_q  <= '0;
            reg_wr_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            cnt_q    <= '0;
        end else begin
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_lo_q  <= ld_lo_d;
            reg_wr_q <= reg_wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reg_wr         = reg_wr_q;
    assign reg_write_addr = addr_q;
    assign reg_din        = din_q;
    assign retire_count   = cnt_q;

`ifdef WB_FWD_EN
    assign fwd_valid = reg_wr_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = din_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_result = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        reg_wr;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_din;
    logic [63:0] retire_count;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_addr_lo     (in_addr_lo),
        .in_result      (in_result),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .reg_wr         (reg_wr),
        .reg_write_addr (reg_write_addr),
        .reg_din        (reg_din),
        .retire_count   (retire_count)
`ifdef WB_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one pending-load slot plus the expected output register.
    bit          m_wait;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_din;
    logic [63:0] e_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
        logic [31:0]        sh_b;
        logic [31:0]        sh_h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        sh_b = w >> {lo, 3'b000};
        sh_h = w >> {lo[1], 4'b0000};
        sb   = sh_b[7:0];
        sh   = sh_h[15:0];
        case (f3)
            3'd0:    r = sb;
            3'd1:    r = sh;
            3'd2:    r = w;
            3'd4:    r = {24'h0, sh_b[7:0]};
            3'd5:    r = {16'h0, sh_h[15:0]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_rd   = '0;
        m_f3   = '0;
        m_lo   = '0;
        e_wr   = 1'b0;
        e_addr = '0;
        e_din  = '0;
        e_cnt  = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".reg_wr"},   {63'h0, reg_wr},         {63'h0, e_wr});
        check({tag, ".addr"},     {59'h0, reg_write_addr}, {59'h0, e_addr});
        check({tag, ".din"},      {32'h0, reg_din},        {32'h0, e_din});
        check({tag, ".count"},    retire_count,            e_cnt);
        check({tag, ".in_ready"}, {63'h0, in_ready},       {63'h0, !m_wait});
`ifdef WB_FWD_EN
        check({tag, ".fwd_valid"}, {63'h0, fwd_valid}, {63'h0, e_wr});
        check({tag, ".fwd_addr"},  {59'h0, fwd_addr},  {59'h0, e_addr});
        check({tag, ".fwd_data"},  {32'h0, fwd_data},  {32'h0, e_din});
`endif
    endtask

    // Predict the effect of the current inputs at the next rising edge,
    // advance past that edge, then compare.
    task automatic step(input string tag);
        bit          fire;
        logic [4:0]  rd;
        logic [31:0] data;
        fire = 0;
        rd   = '0;
        data = '0;
        if (!m_wait) begin
            if (in_valid && !in_is_load) begin
                fire = 1;
                rd   = in_rd;
                data = in_result;
            end else if (in_valid) begin
                m_wait = 1;
                m_rd   = in_rd;
                m_f3   = in_funct3;
                m_lo   = in_addr_lo;
            end
        end else if (mem_rvalid) begin
            fire   = 1;
            rd     = m_rd;
            data   = ref_align(m_f3, m_lo, mem_rdata);
            m_wait = 0;
        end
        e_wr = fire && (rd != 5'd0);
        if (e_wr) begin
            e_addr = rd;
            e_din  = data;
        end
        if (fire) e_cnt = e_cnt + 64'd1;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = rd;
        in_result  = res;
        step("alu");
        in_valid   = 1'b0;
    endtask

    task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = rd;
        in_funct3  = f3;
        in_addr_lo = lo;
        step("load_acc");
        in_valid   = 1'b0;
        in_is_load = 1'b0;
    endtask

    // Response arrives 'lat' edges after acceptance; returns after the write edge.
    task automatic respond(input int lat, input logic [31:0] data);
        for (int i = 1; i < lat; i++) step("load_wait");
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step("load_resp");
        mem_rvalid = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst.reg_wr",   {63'h0, reg_wr},         64'h0);
        check("rst.addr",     {59'h0, reg_write_addr}, 64'h0);
        check("rst.din",      {32'h0, reg_din},        64'h0);
        check("rst.count",    retire_count,            64'h0);
        check("rst.in_ready", {63'h0, in_ready},       64'h1);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check("por.reg_wr",   {63'h0, reg_wr},       64'h0);
        check("por.count",    retire_count,          64'h0);
        check("por.in_ready", {63'h0, in_ready},     64'h1);
        #1 rst_n = 1'b1;

        send_alu(5'd5, 32'h1234_5678);
        check("alu5.reg_wr", {63'h0, reg_wr},         64'h1);
        check("alu5.addr",   {59'h0, reg_write_addr}, 64'd5);
        check("alu5.data",   {32'h0, reg_din},        64'h1234_5678);
        check("alu5.count",  retire_count,            64'd1);
        step("alu5_after");
        check("alu5.pulse",  {63'h0, reg_wr},         64'h0);

        send_load(5'd7, 3'b000, 2'd2);
        check("lb.in_ready", {63'h0, in_ready}, 64'h0);
        respond(3, 32'h0080_0000);
        check("lb.data", {32'h0, reg_din}, 64'hFFFF_FF80);
        step("lb_after");

        send_load(5'd8, 3'b100, 2'd2);
        respond(3, 32'h0080_0000);
        check("lbu.data", {32'h0, reg_din}, 64'h0000_0080);

        send_load(5'd9, 3'b001, 2'd2);
        respond(1, 32'h8001_0000);
        check("lh.data", {32'h0, reg_din}, 64'hFFFF_8001);

        send_load(5'd10, 3'b101, 2'd3);
        respond(2, 32'h8001_0000);
        check("lhu.data", {32'h0, reg_din}, 64'h0000_8001);

        send_load(5'd11, 3'b011, 2'd1);
        respond(2, 32'hFFFF_FFFF);
        check("bad_f3.data", {32'h0, reg_din}, 64'h0);

        send_alu(5'd0, 32'hDEAD_BEEF);
        check("x0.reg_wr", {63'h0, reg_wr}, 64'h0);
        check("x0.count",  retire_count,    64'd7);

        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step("idle_rvalid");
        mem_rvalid = 1'b0;
        check("idle_rvalid.reg_wr", {63'h0, reg_wr}, 64'h0);

        send_load(5'd12, 3'b010, 2'd0);
        step("pre_rst_wait");
        async_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        step("post_rst_rvalid");
        mem_rvalid = 1'b0;
        check("post_rst.reg_wr", {63'h0, reg_wr}, 64'h0);

        @(negedge clk);
        async_reset();
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_rd     = 5'(i);
            in_result = 32'h100 * i;
            step("b2b");
            check("b2b.reg_wr", {63'h0, reg_wr}, 64'h1);
        end
        in_valid = 1'b0;
        send_load(5'd20, 3'b010, 2'd0);
        respond(2, 32'hA5A5_5A5A);
        check("b2b_load.addr", {59'h0, reg_write_addr}, 64'd20);
        check("b2b.count",     retire_count,            64'd5);
        step("b2b_after");

        for (int n = 0; n < 400; n++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_is_load = 1'($urandom_range(0, 1));
            in_rd      = 5'($urandom_range(0, 31));
            in_funct3  = 3'($urandom_range(0, 7));
            in_addr_lo = 2'($urandom_range(0, 3));
            in_result  = $urandom;
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
